// File: rtl/aes256_inv_round_iter_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES-256 inverse cipher.
// The block state is 16 bytes; byte 0 of the AES block lives in element 15 (bits 127:120).
package aes256_inv_round_iter_pkg;

  localparam int DATA_WIDTH = 128;
  localparam int AES_NR     = 14;
  localparam int RK_IDX_W   = 4;

  typedef logic [DATA_WIDTH/8-1:0][7:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } fsm_state_e;

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] base;
    base = 11'd2047 - {b, 3'b000};
    return INV_SBOX[base -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_09(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mul_0b(input logic [7:0] b);
    logic [7:0] x2;
    x2 = xtime(b);
    return xtime(xtime(x2)) ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] mul_0d(input logic [7:0] b);
    logic [7:0] x4;
    x4 = xtime(xtime(b));
    return xtime(x4) ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mul_0e(input logic [7:0] b);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = xtime(b);
    x4 = xtime(x2);
    return xtime(x4) ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/aes256_inv_round_iter_if.sv
// Ciphertext-in / plaintext-out handshake plus the round-key lookup port of the inverse cipher core.
// The master side offers blocks, serves round keys and consumes plaintext; the core is the slave.
interface aes256_inv_round_iter_if;
  import aes256_inv_round_iter_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_text;
  logic [RK_IDX_W-1:0]   rk_idx;
  logic [DATA_WIDTH-1:0] rk_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_text;
  logic                  busy;

  modport master (
    output in_valid, in_text, rk_data, out_ready,
    input  in_ready, rk_idx, out_valid, out_text, busy
  );

  modport slave (
    input  in_valid, in_text, rk_data, out_ready,
    output in_ready, rk_idx, out_valid, out_text, busy
  );

endinterface

// File: rtl/aes256_inv_round_iter_roundop.sv
// One AES inverse round, purely combinational:
// InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless this is the final round.
module aes256_inv_round_iter_roundop
  import aes256_inv_round_iter_pkg::*;
(
  input  state_t input_text,
  input  state_t round_key,
  input  logic   last,
  output state_t output_text
);

  state_t     shifted;
  state_t     keyed;
  state_t     mixed;
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no latch can be inferred.
    shifted = '0;
    mixed   = '0;
    a0      = '0;
    a1      = '0;
    a2      = '0;
    a3      = '0;
    // Row r of column c comes from column (c - r) mod 4; byte index is 4*c + r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[4'(15 - (4 * c + r))] =
          inv_sbox(input_text[4'(15 - (4 * ((c + 4 - r) % 4) + r))]);
      end
    end
    keyed = shifted ^ round_key;
    for (int c = 0; c < 4; c++) begin
      a0 = keyed[4'(15 - 4 * c)];
      a1 = keyed[4'(14 - 4 * c)];
      a2 = keyed[4'(13 - 4 * c)];
      a3 = keyed[4'(12 - 4 * c)];
      mixed[4'(15 - 4 * c)] = mul_0e(a0) ^ mul_0b(a1) ^ mul_0d(a2) ^ mul_09(a3);
      mixed[4'(14 - 4 * c)] = mul_09(a0) ^ mul_0e(a1) ^ mul_0b(a2) ^ mul_0d(a3);
      mixed[4'(13 - 4 * c)] = mul_0d(a0) ^ mul_09(a1) ^ mul_0e(a2) ^ mul_0b(a3);
      mixed[4'(12 - 4 * c)] = mul_0b(a0) ^ mul_0d(a1) ^ mul_09(a2) ^ mul_0e(a3);
    end
  end

  assign output_text = last ? keyed : mixed;

endmodule

// File: rtl/aes256_inv_round_iter.sv
// Iterative AES-256 inverse cipher: rk14 add on accept, then one inverse round per clock
// (rounds 13..0), plaintext held on a valid/ready output until taken.
module aes256_inv_round_iter
  import aes256_inv_round_iter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  aes256_inv_round_iter_if.slave bus
);

  fsm_state_e          fsm_q;
  logic [RK_IDX_W-1:0] rnd_q;
  state_t              data_q;
  state_t              out_text_q;
  logic                hold_q;
  state_t              round_d;
  logic                last_round;

  assign last_round = (rnd_q == '0);

  aes256_inv_round_iter_roundop u_roundop (
    .input_text  (data_q),
    .round_key   (bus.rk_data),
    .last        (last_round),
    .output_text (round_d)
  );

  // NOTE: state registers use non-blocking assignments so every one of them samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset as well, so a run aborted by rst leaves out_text at 0.
      fsm_q      <= ST_IDLE;
      rnd_q      <= '0;
      data_q     <= '0;
      out_text_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      unique case (fsm_q)
        ST_IDLE: begin
          hold_q <= 1'b0;
          if (bus.in_valid && !hold_q) begin
            data_q <= bus.in_text ^ bus.rk_data;
            rnd_q  <= RK_IDX_W'(AES_NR - 1);
            fsm_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          data_q <= round_d;
          if (last_round) begin
            out_text_q <= round_d;
            fsm_q      <= ST_DONE;
          end else begin
            rnd_q <= rnd_q - RK_IDX_W'(1);
          end
        end
        ST_DONE: begin
          // The first IDLE cycle after a hand-off never accepts, giving a 17-cycle block period.
          if (bus.out_ready) begin
            fsm_q  <= ST_IDLE;
            hold_q <= 1'b1;
          end
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (fsm_q == ST_IDLE) && !hold_q;
  assign bus.out_valid = (fsm_q == ST_DONE);
  assign bus.busy      = (fsm_q != ST_IDLE);
  assign bus.rk_idx    = (fsm_q == ST_IDLE) ? RK_IDX_W'(AES_NR) : rnd_q;
  assign bus.out_text  = out_text_q;

endmodule
